// File: rtl/lut_cfg_pkg.sv
// -----------------------------------------------------------------------------
// lut_cfg_pkg
// Shared definitions for the LUT bank configuration controller:
//   - cfg_state_e : load sequencer states (IDLE -> SHIFT -> COMMIT -> IDLE)
//   - LUT_INIT_W  : width of one LUT INIT word (6-input LUT => 64 bits)
//   - clog2       : elaboration-time ceil(log2(n)) for index widths
// Ports: none (package).
// -----------------------------------------------------------------------------
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  localparam int LUT_INIT_W = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lut_bank_lookup.sv
// -----------------------------------------------------------------------------
// lut_bank_lookup
// Active LUT bank storage with one commit write port and a registered
// O6/O5 lookup port. The bank is only ever written by a whole-word commit,
// so lookups never observe a partially loaded word.
// Optional macro LUT_CFG_READBACK_EN adds a registered whole-word readback.
//
// Ports:
//   clk, rst_n            clock / async active-low reset
//   wr_en, wr_idx, wr_data  commit write of a full INIT word
//   lk_valid, lk_sel, lk_in lookup request (LUT select, inputs I5..I0)
//   lk_vld_o, lk_o6, lk_o5  registered lookup result (1-cycle latency)
//   rb_idx, rb_data        (LUT_CFG_READBACK_EN only) registered readback
// -----------------------------------------------------------------------------
module lut_bank_lookup
  import lut_cfg_pkg::*;
#(
  parameter int          N_LUT        = 4,
  parameter int          IDX_W        = 2,
  parameter logic [63:0] INIT_DEFAULT = 64'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [LUT_INIT_W-1:0] wr_data,
  input  logic                  lk_valid,
  input  logic [IDX_W-1:0]      lk_sel,
  input  logic [5:0]            lk_in,
  output logic                  lk_vld_o,
  output logic                  lk_o6,
  output logic                  lk_o5
`ifdef LUT_CFG_READBACK_EN
  ,
  input  logic [IDX_W-1:0]      rb_idx,
  output logic [LUT_INIT_W-1:0] rb_data
`endif
);

  localparam logic [IDX_W:0] N_LUT_C = (IDX_W + 1)'(N_LUT);

  logic [LUT_INIT_W-1:0] bank [N_LUT];
  logic [LUT_INIT_W-1:0] lk_word_p0;
  logic                  lk_sel_ok_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LUT; i++) begin
        bank[i] <= INIT_DEFAULT;
      end
    end else if (wr_en) begin
      bank[wr_idx] <= wr_data;
    end
  end

  // Out-of-range selects read as an all-zero word so O6/O5 come out 0.
  always_comb begin
    lk_sel_ok_p0 = ({1'b0, lk_sel} < N_LUT_C);
    lk_word_p0   = '0;
    if (lk_sel_ok_p0) begin
      lk_word_p0 = bank[lk_sel];
    end
  end

  // ---- stage p0 -> p1: registered lookup ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_vld_o <= 1'b0;
      lk_o6    <= 1'b0;
      lk_o5    <= 1'b0;
    end else begin
      lk_vld_o <= lk_valid;
      if (lk_valid) begin
        lk_o6 <= lk_word_p0[lk_in];
        lk_o5 <= lk_word_p0[{1'b0, lk_in[4:0]}];
      end
    end
  end

`ifdef LUT_CFG_READBACK_EN
  logic rb_ok_p0;
  assign rb_ok_p0 = ({1'b0, rb_idx} < N_LUT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data <= '0;
    end else if (rb_ok_p0) begin
      rb_data <= bank[rb_idx];
    end else begin
      rb_data <= '0;
    end
  end
`else
  // Readback disabled: no readback ports or storage taps.
`endif

endmodule

// File: rtl/lut_bank_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// lut_bank_cfg_ctrl
// Configuration controller for a bank of N_LUT 6-input/dual-output LUTs
// (O6 = INIT[I5..I0], O5 = INIT[I4..I0]). A 64-bit INIT word accepted on the
// valid/ready command port is shifted SHIFT_W bits per cycle into a shadow
// register, then committed in one cycle to the active bank. Lookups are
// served from the active bank every cycle, independent of any load.
// Optional macro LUT_CFG_READBACK_EN adds rb_idx/rb_data whole-word readback.
//
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   cmd_valid, cmd_ready          command handshake
//   cmd_idx, cmd_init             target LUT and new INIT word
//   cfg_busy                      load in progress (SHIFT or COMMIT)
//   cfg_done                      one-cycle pulse during COMMIT
//   cfg_err                       one-cycle pulse after an out-of-range cmd_idx
//   lk_valid, lk_sel, lk_in       lookup request
//   lk_vld_o, lk_o6, lk_o5        registered lookup result
//   rb_idx, rb_data               (LUT_CFG_READBACK_EN only) readback
// -----------------------------------------------------------------------------
module lut_bank_cfg_ctrl
  import lut_cfg_pkg::*;
#(
  parameter int          N_LUT        = 4,
  parameter int          SHIFT_W      = 8,
  parameter logic [63:0] INIT_DEFAULT = 64'h0,
  localparam int         IDX_W        = clog2(N_LUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [IDX_W-1:0]      cmd_idx,
  input  logic [LUT_INIT_W-1:0] cmd_init,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic                  lk_valid,
  input  logic [IDX_W-1:0]      lk_sel,
  input  logic [5:0]            lk_in,
  output logic                  lk_vld_o,
  output logic                  lk_o6,
  output logic                  lk_o5
`ifdef LUT_CFG_READBACK_EN
  ,
  input  logic [IDX_W-1:0]      rb_idx,
  output logic [LUT_INIT_W-1:0] rb_data
`endif
);

  localparam int             N_SHIFT  = LUT_INIT_W / SHIFT_W;
  localparam logic [6:0]     LAST_CNT = 7'(N_SHIFT - 1);
  localparam logic [IDX_W:0] N_LUT_C  = (IDX_W + 1)'(N_LUT);

  cfg_state_e            state;
  logic [IDX_W-1:0]      buf_idx;
  logic [LUT_INIT_W-1:0] buf_init;
  logic [LUT_INIT_W-1:0] shadow;
  logic [6:0]            cnt;
  logic [SHIFT_W-1:0]    chunk;
  logic                  accept;
  logic                  idx_ok;

  // New chunk enters at the top; after N_SHIFT steps chunk 0 sits at bit 0.
  // Written as shifts so SHIFT_W = 64 needs no zero-width slice.
  function automatic logic [LUT_INIT_W-1:0] shift_in(
    input logic [LUT_INIT_W-1:0] cur,
    input logic [SHIFT_W-1:0]    ins
  );
    return (cur >> SHIFT_W) | (LUT_INIT_W'(ins) << (LUT_INIT_W - SHIFT_W));
  endfunction

  always_comb begin
    chunk  = SHIFT_W'(buf_init >> (SHIFT_W * int'(cnt)));
    accept = cmd_valid && cmd_ready;
    idx_ok = ({1'b0, cmd_idx} < N_LUT_C);
  end

  // Command buffer is pure data; it is only consumed after a fresh accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_idx  <= cmd_idx;
      buf_init <= cmd_init;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      shadow    <= INIT_DEFAULT;
      cnt       <= '0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (idx_ok) begin
              state     <= SHIFT;
              cmd_ready <= 1'b0;
              cfg_busy  <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shadow <= shift_in(shadow, chunk);
          if (cnt == LAST_CNT) begin
            cnt      <= '0;
            state    <= COMMIT;
            cfg_done <= 1'b1;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        COMMIT: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          cfg_busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          cfg_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- commit boundary: bank written on the closing edge of COMMIT ----
  logic wr_en;
  assign wr_en = (state == COMMIT);

  lut_bank_lookup #(
    .N_LUT        (N_LUT),
    .IDX_W        (IDX_W),
    .INIT_DEFAULT (INIT_DEFAULT)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_idx   (buf_idx),
    .wr_data  (shadow),
    .lk_valid (lk_valid),
    .lk_sel   (lk_sel),
    .lk_in    (lk_in),
    .lk_vld_o (lk_vld_o),
    .lk_o6    (lk_o6),
    .lk_o5    (lk_o5)
`ifdef LUT_CFG_READBACK_EN
    ,
    .rb_idx   (rb_idx),
    .rb_data  (rb_data)
`endif
  );

endmodule

// File: tb/tb_lut_bank_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lut_bank_cfg_ctrl
// Directed bench for lut_bank_cfg_ctrl (N_LUT=3 so index 3 is out of range,
// SHIFT_W=8). Lookup expectations come from a bench-side copy of the bank
// pushed to a queue when a lookup is driven and popped when lk_vld_o rises.
// Readback checks are compiled in when LUT_CFG_READBACK_EN is defined.
// -----------------------------------------------------------------------------
module tb_lut_bank_cfg_ctrl;

  localparam int          N_LUT        = 3;
  localparam int          SHIFT_W      = 8;
  localparam int          IDX_W        = 2;
  localparam logic [63:0] INIT_DEFAULT = 64'h0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IDX_W-1:0]  cmd_idx;
  logic [63:0]       cmd_init;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;
  logic              lk_valid;
  logic [IDX_W-1:0]  lk_sel;
  logic [5:0]        lk_in;
  logic              lk_vld_o;
  logic              lk_o6;
  logic              lk_o5;
`ifdef LUT_CFG_READBACK_EN
  logic [IDX_W-1:0]  rb_idx;
  logic [63:0]       rb_data;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] model [N_LUT];
  logic [1:0]  sb_q [$];

  always #5 clk = ~clk;

  lut_bank_cfg_ctrl #(
    .N_LUT        (N_LUT),
    .SHIFT_W      (SHIFT_W),
    .INIT_DEFAULT (INIT_DEFAULT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_idx   (cmd_idx),
    .cmd_init  (cmd_init),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .lk_valid  (lk_valid),
    .lk_sel    (lk_sel),
    .lk_in     (lk_in),
    .lk_vld_o  (lk_vld_o),
    .lk_o6     (lk_o6),
    .lk_o5     (lk_o5)
`ifdef LUT_CFG_READBACK_EN
    ,
    .rb_idx    (rb_idx),
    .rb_data   (rb_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] exp_lk(input logic [IDX_W-1:0] sel, input logic [5:0] in);
    logic [63:0] w;
    w = '0;
    if (int'(sel) < N_LUT) w = model[sel];
    return {w[in], w[{1'b0, in[4:0]}]};
  endfunction

  // Scoreboard consumer: every lookup driven before an edge must return right after it.
  always @(posedge clk) begin
    logic [1:0] e;
    #1;
    if (rst_n === 1'b1) begin
      if (lk_vld_o === 1'b1) begin
        chk("lk_vld_expected", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("lk_o6o5", {62'd0, lk_o6, lk_o5}, {62'd0, e});
        end
      end else if (sb_q.size() > 0) begin
        chk("lk_vld_missing", {63'd0, lk_vld_o}, 64'd1);
        void'(sb_q.pop_front());
      end
    end
  end

  // One clock: record the expected lookup result, then move past the edge.
  task automatic cycle();
    if (lk_valid) sb_q.push_back(exp_lk(lk_sel, lk_in));
    @(posedge clk);
    #2;
  endtask

  task automatic lk_expect(input string tag, input logic [IDX_W-1:0] sel,
                           input logic [5:0] in, input logic o6, input logic o5);
    lk_valid = 1'b1;
    lk_sel   = sel;
    lk_in    = in;
    cycle();
    lk_valid = 1'b0;
    chk({tag, "_o6"}, {63'd0, lk_o6}, {63'd0, o6});
    chk({tag, "_o5"}, {63'd0, lk_o5}, {63'd0, o5});
  endtask

  task automatic check_lut(input logic [IDX_W-1:0] sel);
    for (int i = 0; i < 64; i++) begin
      lk_valid = 1'b1;
      lk_sel   = sel;
      lk_in    = 6'(i);
      cycle();
    end
    lk_valid = 1'b0;
    cycle();
  endtask

  task automatic load(input logic [IDX_W-1:0] idx, input logic [63:0] w, input bit ok,
                      input bit hold, input logic [IDX_W-1:0] nidx, input logic [63:0] nw);
    cmd_valid = 1'b1;
    cmd_idx   = idx;
    cmd_init  = w;
    chk("ready_before_accept", {63'd0, cmd_ready}, 64'd1);
    cycle();
    if (hold) begin
      cmd_idx  = nidx;
      cmd_init = nw;
    end else begin
      cmd_valid = 1'b0;
    end
    if (!ok) begin
      chk("err_pulse", {63'd0, cfg_err}, 64'd1);
      chk("err_ready", {63'd0, cmd_ready}, 64'd1);
      chk("err_busy", {63'd0, cfg_busy}, 64'd0);
      cycle();
      chk("err_single", {63'd0, cfg_err}, 64'd0);
      chk("err_no_done", {63'd0, cfg_done}, 64'd0);
      return;
    end
    for (int n = 1; n <= 9; n++) begin
      chk("load_ready_low", {63'd0, cmd_ready}, 64'd0);
      chk("load_busy", {63'd0, cfg_busy}, 64'd1);
      chk("load_done_timing", {63'd0, cfg_done}, 64'(n == 9));
      chk("load_no_err", {63'd0, cfg_err}, 64'd0);
      if (n < 9) cycle();
    end
    cycle();
    model[idx] = w;
    chk("post_done_low", {63'd0, cfg_done}, 64'd0);
    chk("post_ready", {63'd0, cmd_ready}, 64'd1);
    chk("post_busy", {63'd0, cfg_busy}, 64'd0);
  endtask

`ifdef LUT_CFG_READBACK_EN
  task automatic check_rb();
    for (int i = 0; i < 4; i++) begin
      rb_idx = IDX_W'(i);
      cycle();
      chk("readback", rb_data, (i < N_LUT) ? model[i] : 64'h0);
    end
  endtask
`endif

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, cmd_ready}, 64'd1);
    chk({tag, "_busy"}, {63'd0, cfg_busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, cfg_done}, 64'd0);
    chk({tag, "_err"}, {63'd0, cfg_err}, 64'd0);
    chk({tag, "_vld"}, {63'd0, lk_vld_o}, 64'd0);
    chk({tag, "_o6o5"}, {62'd0, lk_o6, lk_o5}, 64'd0);
`ifdef LUT_CFG_READBACK_EN
    chk({tag, "_rb"}, rb_data, 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_idx   = '0;
    cmd_init  = '0;
    lk_valid  = 1'b0;
    lk_sel    = '0;
    lk_in     = '0;
`ifdef LUT_CFG_READBACK_EN
    rb_idx    = '0;
`endif
    for (int i = 0; i < N_LUT; i++) model[i] = INIT_DEFAULT;

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycle();

    // Default contents: LUT0 reads 0, valid follows one cycle later.
    lk_expect("dflt", 2'd0, 6'd5, 1'b0, 1'b0);
    chk("dflt_vld", {63'd0, lk_vld_o}, 64'd1);
    chk("dflt_ready", {63'd0, cmd_ready}, 64'd1);

    // Load LUT1 with corner bits set, then probe O6/O5 semantics.
    load(2'd1, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 2'd0, 64'h0);
    lk_expect("i0", 2'd1, 6'd0, 1'b1, 1'b1);
    lk_expect("i63", 2'd1, 6'd63, 1'b1, 1'b0);
    lk_expect("i32", 2'd1, 6'd32, 1'b0, 1'b1);
    cycle();
    chk("hold_vld", {63'd0, lk_vld_o}, 64'd0);
    chk("hold_o6o5", {62'd0, lk_o6, lk_o5}, 64'd1);

    // Coherency: continuous LUT1 lookups across a load of all-zero.
    lk_valid = 1'b1;
    lk_sel   = 2'd1;
    lk_in    = 6'd0;
    load(2'd1, 64'h0, 1'b1, 1'b0, 2'd0, 64'h0);
    chk("coh_commit_edge_o6", {63'd0, lk_o6}, 64'd1);
    cycle();
    chk("coh_after_commit_o6", {63'd0, lk_o6}, 64'd0);
    lk_valid = 1'b0;
    cycle();

    // Populate distinct patterns, then an out-of-range command.
    load(2'd0, 64'hA5A5_0F0F_3C3C_FF00, 1'b1, 1'b0, 2'd0, 64'h0);
    load(2'd2, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 2'd0, 64'h0);
    load(2'd3, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 2'd0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("err_idle_no_done", {63'd0, cfg_done}, 64'd0);
      cycle();
    end
    check_lut(2'd0);
    check_lut(2'd1);
    check_lut(2'd2);
    lk_expect("sel_oor", 2'd3, 6'd63, 1'b0, 1'b0);
    chk("sel_oor_vld", {63'd0, lk_vld_o}, 64'd1);
`ifdef LUT_CFG_READBACK_EN
    check_rb();
`endif

    // Reset during SHIFT cycle 4: load abandoned, bank back to default.
    cmd_valid = 1'b1;
    cmd_idx   = 2'd1;
    cmd_init  = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    cmd_valid = 1'b0;
    repeat (3) cycle();
    chk("midshift_busy", {63'd0, cfg_busy}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midshift_rst");
    sb_q.delete();
    for (int i = 0; i < N_LUT; i++) model[i] = INIT_DEFAULT;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("midshift_no_done", {63'd0, cfg_done}, 64'd0);
    end
    check_lut(2'd1);
    check_lut(2'd0);

    // Back-to-back: second command held while busy, accepted after COMMIT.
    load(2'd0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1, 2'd2, 64'h5555_AAAA_0000_FFFF);
    load(2'd2, 64'h5555_AAAA_0000_FFFF, 1'b1, 1'b0, 2'd0, 64'h0);
    check_lut(2'd0);
    check_lut(2'd2);
    check_lut(2'd1);
`ifdef LUT_CFG_READBACK_EN
    check_rb();
`endif

    cycle();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
